// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } arb_state_e;

  localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hF0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first set request scanning upward from ptr_i, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] gnt_rot;

  // Rotate so ptr_i lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_rot = NUM_REQ'({req_i, req_i} >> ptr_i);
    gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
    grant_o = NUM_REQ'(({gnt_rot, gnt_rot} << ptr_i) >> NUM_REQ);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ packet requesters: round-robin grant held
// for a whole packet, optional index header byte, and a mid-packet stall watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned          NUM_REQ     = 4,
  parameter int unsigned          DATA_BITS   = 8,
  parameter bit                   HEADER_EN   = 1'b1,
  parameter logic [DATA_BITS-1:0] HEADER_BASE = DATA_BITS'(HEADER_BASE_DEFAULT),
  parameter int unsigned          TIMEOUT     = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_last,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_tx_valid,
  output logic [DATA_BITS-1:0]         o_tx_data,
  input  logic                         i_tx_ready,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy,
  output logic                         o_abort
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                abort_q;

  logic [NUM_REQ-1:0]  grant_d;
  logic [IDX_W-1:0]    idx_d;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic [WDOG_W-1:0]   wdog_inc;

  logic                sel_valid;
  logic                sel_last;
  logic [DATA_BITS-1:0] sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (i_req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_d)
  );

  // Encode the arbiter's one-hot pick and derive the pointer for the next round.
  always_comb begin
    idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) idx_d = IDX_W'(i);
    end
    rr_ptr_d = (idx_d == IDX_W'(NUM_REQ - 1)) ? '0 : idx_d + IDX_W'(1);
  end

  // Select the granted requester's byte stream.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) sel_data = i_req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign sel_valid = |(i_req_valid & grant_q);
  assign sel_last  = |(i_req_last & grant_q);
  assign wdog_inc  = wdog_q + WDOG_W'(1);

  // Arbitration FSM with watchdog; grant stays fixed from header to last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|i_req_valid) begin
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= '0;
            state_q  <= HEADER_EN ? HEADER : DATA;
          end
        end
        HEADER: begin
          if (i_tx_ready) state_q <= DATA;
        end
        DATA: begin
          if (sel_valid) begin
            wdog_q <= '0;
            if (i_tx_ready && sel_last) begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (TIMEOUT != 0) begin
            if (wdog_inc == WDOG_LIMIT) begin
              abort_q <= 1'b1;
              state_q <= IDLE;
              grant_q <= '0;
              wdog_q  <= '0;
            end else begin
              wdog_q <= wdog_inc;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Header comes from the arbiter; data is a zero-latency pass-through.
  always_comb begin
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    case (state_q)
      HEADER: begin
        o_tx_valid = 1'b1;
        o_tx_data  = HEADER_BASE | DATA_BITS'(idx_q);
      end
      DATA: begin
        o_tx_valid  = sel_valid;
        o_tx_data   = sel_data;
        o_req_ready = grant_q & {NUM_REQ{i_tx_ready}};
      end
      default: ;
    endcase
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != IDLE);
  assign o_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two configurations share requester models.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic            tx_ready;

  logic [3:0] ready_a, grant_a;
  logic       txv_a, busy_a, abort_a;
  logic [7:0] txd_a;
  logic [1:0] ready_b, grant_b;
  logic       txv_b, busy_b, abort_b;
  logic [7:0] txd_b;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_BITS(8), .HEADER_EN(1'b1), .HEADER_BASE(8'hF0), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(ready_a), .o_tx_valid(txv_a), .o_tx_data(txd_a), .i_tx_ready(tx_ready),
    .o_grant(grant_a), .o_busy(busy_a), .o_abort(abort_a)
  );

  uart_tx_arbiter #(
    .NUM_REQ(2), .DATA_BITS(8), .HEADER_EN(1'b0), .HEADER_BASE(8'hF0), .TIMEOUT(0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid[1:0]), .i_req_data(req_data[15:0]), .i_req_last(req_last[1:0]),
    .o_req_ready(ready_b), .o_tx_valid(txv_b), .o_tx_data(txd_b), .i_tx_ready(tx_ready),
    .o_grant(grant_b), .o_busy(busy_b), .o_abort(abort_b)
  );

  bit         sel2 = 1'b0;
  logic [3:0] rdy_s, grant_s;
  logic       txv_s, abort_s;
  logic [7:0] txd_s;
  assign rdy_s   = sel2 ? {2'b00, ready_b} : ready_a;
  assign grant_s = sel2 ? {2'b00, grant_b} : grant_a;
  assign txv_s   = sel2 ? txv_b : txv_a;
  assign txd_s   = sel2 ? txd_b : txd_a;
  assign abort_s = sel2 ? abort_b : abort_a;

  logic [7:0] rb [NR][8];
  bit         rl [NR][8];
  int         rlen [NR];
  int         rpos [NR];
  int         rgate [NR];

  logic [7:0] tx_log [$];
  logic [3:0] g_log [$];
  int         c_log [$];
  int         abort_cyc [$];
  int         cyc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int i, input logic [7:0] eb, input logic [3:0] eg);
    if (i < tx_log.size()) begin
      chk({tag, "_byte"}, 32'(tx_log[i]), 32'(eb));
      chk({tag, "_grant"}, 32'(g_log[i]), 32'(eg));
    end else begin
      chk({tag, "_missing"}, tx_log.size(), i + 1);
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < NR; k++) begin
      req_valid[k]        = (rpos[k] < rlen[k]) && (rpos[k] < rgate[k]);
      req_data[k*8 +: 8]  = rb[k][rpos[k] % 8];
      req_last[k]         = rl[k][rpos[k] % 8];
    end
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NR; k++) begin
      rlen[k] = 0; rpos[k] = 0; rgate[k] = 99;
    end
  endtask

  task automatic load(input int k, input int len, input logic [63:0] bytes, input logic [7:0] lastm);
    rlen[k] = len;
    for (int j = 0; j < 8; j++) begin
      rb[k][j] = bytes[j*8 +: 8];
      rl[k][j] = lastm[j];
    end
  endtask

  // Sample mid-cycle, log accepted tx bytes, advance requesters, then drive the next cycle.
  task automatic tick();
    @(negedge clk);
    if (txv_s && tx_ready) begin
      tx_log.push_back(txd_s); g_log.push_back(grant_s); c_log.push_back(cyc);
    end
    if (abort_s) abort_cyc.push_back(cyc);
    for (int k = 0; k < NR; k++) if (req_valid[k] && rdy_s[k]) rpos[k]++;
    @(posedge clk); #1;
    cyc++;
    drive_reqs();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_ready = 1'b1;
    tx_log.delete(); g_log.delete(); c_log.delete(); abort_cyc.delete();
    for (int k = 0; k < NR; k++) rpos[k] = 0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; cyc = 0;
    drive_reqs();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Single requester with header
    clear_reqs();
    load(1, 2, 64'h4241, 8'b10);
    do_reset();
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_busy",  32'(busy_a), 0);
    chk("rst_txv",   32'(txv_a), 0);
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_abort", 32'(abort_a), 0);
    repeat (8) tick();
    chk("t1_len", tx_log.size(), 3);
    chk_log("t1_0", 0, 8'hF1, 4'b0010);
    chk_log("t1_1", 1, 8'h41, 4'b0010);
    chk_log("t1_2", 2, 8'h42, 4'b0010);
    if (c_log.size() > 0) chk("t1_first_latency", c_log[0], 1);
    chk("t1_end_grant", 32'(grant_a), 0);
    chk("t1_end_busy", 32'(busy_a), 0);

    // Four simultaneous single-byte packets
    clear_reqs();
    for (int k = 0; k < NR; k++) load(k, 1, 64'(8'hA0 + k), 8'b1);
    do_reset();
    repeat (16) tick();
    chk("t2_len", tx_log.size(), 8);
    for (int k = 0; k < NR; k++) begin
      chk_log($sformatf("t2_hdr%0d", k), 2*k, 8'(8'hF0 + k), 4'(1 << k));
      chk_log($sformatf("t2_dat%0d", k), 2*k + 1, 8'(8'hA0 + k), 4'(1 << k));
    end
    if (c_log.size() == 8) begin
      chk("t2_first_latency", c_log[0], 1);
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("t2_hdr_to_dat%0d", k), c_log[2*k+1] - c_log[2*k], 1);
        if (k > 0) chk($sformatf("t2_gap%0d", k), c_log[2*k] - c_log[2*k-1], 2);
      end
    end

    // Backpressure during a 3-byte packet
    clear_reqs();
    load(0, 3, 64'h332211, 8'b100);
    do_reset();
    begin
      bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
        tx_ready = pat[i];
        #1;
        if (i == 3 || i == 4) begin
          chk($sformatf("t3_hold_v%0d", i), 32'(txv_a), 1);
          chk($sformatf("t3_hold_d%0d", i), 32'(txd_a), 32'h22);
        end
        tick();
      end
    end
    tx_ready = 1'b1;
    repeat (2) tick();
    chk("t3_len", tx_log.size(), 4);
    chk_log("t3_0", 0, 8'hF0, 4'b0001);
    chk_log("t3_1", 1, 8'h11, 4'b0001);
    chk_log("t3_2", 2, 8'h22, 4'b0001);
    chk_log("t3_3", 3, 8'h33, 4'b0001);
    if (c_log.size() == 4) chk("t3_last_cycle", c_log[3], 6);
    chk("t3_no_abort", abort_cyc.size(), 0);

    // Stall watchdog, TIMEOUT = 8
    clear_reqs();
    load(2, 2, 64'h6655, 8'b10);
    rgate[2] = 1;
    load(3, 1, 64'h77, 8'b1);
    do_reset();
    repeat (20) tick();
    chk("t4_abort_cnt", abort_cyc.size(), 1);
    chk("t4_len", tx_log.size(), 4);
    chk_log("t4_0", 0, 8'hF2, 4'b0100);
    chk_log("t4_1", 1, 8'h55, 4'b0100);
    chk_log("t4_2", 2, 8'hF3, 4'b1000);
    chk_log("t4_3", 3, 8'h77, 4'b1000);
    if (abort_cyc.size() == 1 && c_log.size() >= 3) begin
      chk("t4_stall_cycles", abort_cyc[0] - c_log[1] - 1, 8);
      chk("t4_rearb", c_log[2], abort_cyc[0] + 1);
    end

    // Reset in the middle of a packet
    clear_reqs();
    load(1, 3, 64'h838281, 8'b100);
    load(0, 1, 64'h90, 8'b1);
    load(3, 1, 64'h93, 8'b1);
    rgate[0] = 0; rgate[3] = 0;
    do_reset();
    abort_cyc.delete();
    repeat (3) tick();
    chk("t5_pre_grant", 32'(grant_a), 32'b0010);
    chk("t5_pre_data", 32'(txd_a), 32'h82);
    rst = 1'b1; rgate[0] = 99; rgate[3] = 99;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_grant", 32'(grant_a), 0);
    chk("t5_busy",  32'(busy_a), 0);
    chk("t5_txv",   32'(txv_a), 0);
    chk("t5_ready", 32'(ready_a), 0);
    chk("t5_abort", 32'(abort_a), 0);
    tick();
    chk("t5_rearb_grant", 32'(grant_a), 32'b0001);
    chk("t5_rearb_hdr", 32'(txd_a), 32'hF0);
    repeat (6) tick();
    chk("t5_no_abort", abort_cyc.size(), 0);

    // Two requesters, no header, alternating grants
    sel2 = 1'b1;
    clear_reqs();
    load(0, 3, 64'hA3A2A1, 8'b110);
    load(1, 1, 64'hB1, 8'b1);
    do_reset();
    chk("t6_rst_grant", 32'(grant_b), 0);
    repeat (10) tick();
    chk("t6_len", tx_log.size(), 4);
    chk_log("t6_0", 0, 8'hA1, 4'b0001);
    chk_log("t6_1", 1, 8'hA2, 4'b0001);
    chk_log("t6_2", 2, 8'hB1, 4'b0010);
    chk_log("t6_3", 3, 8'hA3, 4'b0001);
    if (c_log.size() == 4) begin
      chk("t6_first_latency", c_log[0], 1);
      chk("t6_gap1", c_log[2] - c_log[1], 2);
      chk("t6_gap2", c_log[3] - c_log[2], 2);
    end
    chk("t6_end_busy", 32'(busy_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
